// File: rtl/reg_read_stage.sv
// Register-read stage: one independent lane per functional unit. Captures an issued
// micro-op (S1), resolves both operands from bypass/register file, presents a registered bundle (S2).
module reg_read_stage #(
  parameter int NUM_FUS   = 4,
  parameter int NUM_PREGS = 64,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int ROB_W     = 5,
  parameter int OP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid     [NUM_FUS],
  output logic              iss_ready     [NUM_FUS],
  input  logic [PREG_W-1:0] iss_src1_preg [NUM_FUS],
  input  logic [PREG_W-1:0] iss_src2_preg [NUM_FUS],
  input  logic [PREG_W-1:0] iss_dst_preg  [NUM_FUS],
  input  logic [ROB_W-1:0]  iss_rob_idx   [NUM_FUS],
  input  logic [OP_W-1:0]   iss_op        [NUM_FUS],
  input  logic [31:0]       iss_imm       [NUM_FUS],
  input  logic              iss_use_imm   [NUM_FUS],
  output logic [PREG_W-1:0] prf_src1_reg  [NUM_FUS],
  output logic [PREG_W-1:0] prf_src2_reg  [NUM_FUS],
  input  logic [31:0]       prf_src1_val  [NUM_FUS],
  input  logic [31:0]       prf_src2_val  [NUM_FUS],
  input  logic              wb_valid      [NUM_FUS],
  input  logic [PREG_W-1:0] wb_dst_preg   [NUM_FUS],
  input  logic [31:0]       wb_val        [NUM_FUS],
  output logic              ex_valid      [NUM_FUS],
  input  logic              ex_ready      [NUM_FUS],
  output logic [OP_W-1:0]   ex_op         [NUM_FUS],
  output logic [31:0]       ex_src1_val   [NUM_FUS],
  output logic [31:0]       ex_src2_val   [NUM_FUS],
  output logic [PREG_W-1:0] ex_dst_preg   [NUM_FUS],
  output logic [ROB_W-1:0]  ex_rob_idx    [NUM_FUS]
);

  // Handshakes (issue and ex): a transfer happens at a rising edge where valid && ready;
  // valid never depends on ready, and ex_* holds bit-exact while valid && !ready.

  logic              s1_valid   [NUM_FUS];
  logic [PREG_W-1:0] s1_src1    [NUM_FUS];
  logic [PREG_W-1:0] s1_src2    [NUM_FUS];
  logic [PREG_W-1:0] s1_dst     [NUM_FUS];
  logic [ROB_W-1:0]  s1_rob     [NUM_FUS];
  logic [OP_W-1:0]   s1_op      [NUM_FUS];
  logic [31:0]       s1_imm     [NUM_FUS];
  logic              s1_use_imm [NUM_FUS];

  logic              s2_free    [NUM_FUS];
  logic [31:0]       op1        [NUM_FUS];
  logic [31:0]       op2        [NUM_FUS];

  always_comb begin
    for (int i = 0; i < NUM_FUS; i++) begin
      s2_free[i]      = !ex_valid[i] || ex_ready[i];
      iss_ready[i]    = !flush && (!s1_valid[i] || s2_free[i]);
      prf_src1_reg[i] = s1_valid[i] ? s1_src1[i] : '0;
      prf_src2_reg[i] = s1_valid[i] ? s1_src2[i] : '0;

      // Walk writeback lanes high to low so the lowest matching lane overrides last.
      op1[i] = prf_src1_val[i];
      op2[i] = prf_src2_val[i];
      for (int j = NUM_FUS - 1; j >= 0; j--) begin
        if (wb_valid[j] && (wb_dst_preg[j] == s1_src1[i])) op1[i] = wb_val[j];
        if (wb_valid[j] && (wb_dst_preg[j] == s1_src2[i])) op2[i] = wb_val[j];
      end
      if (s1_src1[i] == '0) op1[i] = '0;
      if (s1_src2[i] == '0) op2[i] = '0;
      if (s1_use_imm[i])    op2[i] = s1_imm[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FUS; i++) begin
      if (rst) begin
        s1_valid[i]    <= 1'b0;
        s1_src1[i]     <= '0;
        s1_src2[i]     <= '0;
        s1_dst[i]      <= '0;
        s1_rob[i]      <= '0;
        s1_op[i]       <= '0;
        s1_imm[i]      <= '0;
        s1_use_imm[i]  <= 1'b0;
        ex_valid[i]    <= 1'b0;
        ex_op[i]       <= '0;
        ex_src1_val[i] <= '0;
        ex_src2_val[i] <= '0;
        ex_dst_preg[i] <= '0;
        ex_rob_idx[i]  <= '0;
      end else if (flush) begin
        s1_valid[i] <= 1'b0;
        ex_valid[i] <= 1'b0;
      end else begin
        if (s2_free[i]) begin
          ex_valid[i] <= s1_valid[i];
          if (s1_valid[i]) begin
            ex_op[i]       <= s1_op[i];
            ex_src1_val[i] <= op1[i];
            ex_src2_val[i] <= op2[i];
            ex_dst_preg[i] <= s1_dst[i];
            ex_rob_idx[i]  <= s1_rob[i];
          end
        end

        if (iss_valid[i] && iss_ready[i]) begin
          s1_valid[i]   <= 1'b1;
          s1_src1[i]    <= iss_src1_preg[i];
          s1_src2[i]    <= iss_src2_preg[i];
          s1_dst[i]     <= iss_dst_preg[i];
          s1_rob[i]     <= iss_rob_idx[i];
          s1_op[i]      <= iss_op[i];
          s1_imm[i]     <= iss_imm[i];
          s1_use_imm[i] <= iss_use_imm[i];
        end else if (s1_valid[i] && s2_free[i]) begin
          s1_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
